multicycle_control_unit: RTL and testbench

//  Next-generation RV32I control: a multi-cycle FSM that sequences fetch/decode/execute/memory/writeback

---
 rtl/multicycle_control_unit.sv | 307 ++++++++++++++++++++++++++++++
 tb/tb_multicycle_control_unit.sv | 329 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/multicycle_control_unit.sv
// multicycle_control_unit
//   Multi-cycle RV32I control FSM. Sequences fetch, decode, execute, memory and
//   writeback over a single shared memory port with a req/ready handshake,
//   holds the instruction register, decodes the datapath selects, raises a
//   sticky trap on illegal opcodes or memory timeouts, and counts retired
//   instructions.
//
// Ports
//   clk, rst_n            clock, asynchronous active-low reset
//   mem_rdata, mem_ready  memory read data / access-complete strobe
//   BrEq, BrLT            branch comparator results (used in EXEC)
//   mem_req, mem_we       memory request (held until ready), store select
//   AddrSel               0 = PC drives memory address, 1 = ALU result
//   ir                    instruction register
//   PCWrite, RegWEn       PC / register-file write enables (one-cycle pulses)
//   PCSel                 0 = PC+4, 1 = ALU result
//   ImmSel, ASel, BSel, BrUn, WBSel, ALUControl   datapath selects
//   trap, trap_cause      sticky halt flag, cause (01 illegal, 10 timeout)
//   instret               retired-instruction counter (wraps)

module multicycle_control_unit #(
  parameter int MEM_TIMEOUT = 255,
  parameter int CNT_W       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [31:0]      mem_rdata,
  input  logic             mem_ready,
  input  logic             BrEq,
  input  logic             BrLT,
  output logic             mem_req,
  output logic             mem_we,
  output logic             AddrSel,
  output logic [31:0]      ir,
  output logic             PCWrite,
  output logic             RegWEn,
  output logic             PCSel,
  output logic [2:0]       ImmSel,
  output logic             ASel,
  output logic             BSel,
  output logic             BrUn,
  output logic [1:0]       WBSel,
  output logic [3:0]       ALUControl,
  output logic             trap,
  output logic [1:0]       trap_cause,
  output logic [CNT_W-1:0] instret
);

  localparam int WAIT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;

  localparam logic [3:0] ALU_ADD  = 4'h0;
  localparam logic [3:0] ALU_SUB  = 4'h1;
  localparam logic [3:0] ALU_AND  = 4'h2;
  localparam logic [3:0] ALU_OR   = 4'h3;
  localparam logic [3:0] ALU_XOR  = 4'h4;
  localparam logic [3:0] ALU_SLL  = 4'h5;
  localparam logic [3:0] ALU_SRL  = 4'h6;
  localparam logic [3:0] ALU_SRA  = 4'h7;
  localparam logic [3:0] ALU_SLT  = 4'h8;
  localparam logic [3:0] ALU_SLTU = 4'h9;
  localparam logic [3:0] ALU_PASSB = 4'hA;

  typedef enum logic [2:0] {
    S_RST, S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_TRAP
  } state_t;

  state_t            state, state_nxt;
  logic [WAIT_W-1:0] wait_cnt;
  logic [1:0]        cause_nxt;
  logic              ir_load, retire, waiting, timed_out, show_sel;

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic       funct7b5;
  logic       legal, is_load, is_store, is_branch, is_jump, br_taken;
  logic [2:0] dec_imm;
  logic       dec_asel, dec_bsel;
  logic [1:0] dec_wbsel;
  logic [3:0] dec_alu;

  assign opcode   = ir[6:0];
  assign funct3   = ir[14:12];
  assign funct7b5 = ir[30];
  assign trap     = (state == S_TRAP);

  // funct3 -> ALU op for register and immediate arithmetic; SUB only exists
  // for register form, since bit 30 of an I-type is immediate data
  function automatic logic [3:0] arith_op(input logic [2:0] f3, input logic b5,
                                          input logic is_reg);
    case (f3)
      3'b000:  arith_op = (is_reg && b5) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010:  arith_op = ALU_SLT;
      3'b011:  arith_op = ALU_SLTU;
      3'b100:  arith_op = ALU_XOR;
      3'b101:  arith_op = b5 ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  endfunction

  // Static decode of the instruction register into datapath selects and
  // instruction class flags; the FSM decides when they are presented
  always_comb begin
    dec_imm   = 3'b000;
    dec_asel  = 1'b0;
    dec_bsel  = 1'b0;
    dec_wbsel = 2'b00;
    dec_alu   = ALU_ADD;
    legal     = 1'b1;
    is_load   = 1'b0;
    is_store  = 1'b0;
    is_branch = 1'b0;
    is_jump   = 1'b0;
    case (opcode)
      OP_REG: begin
        dec_wbsel = 2'b01;
        dec_alu   = arith_op(funct3, funct7b5, 1'b1);
      end
      OP_IMM: begin
        dec_bsel  = 1'b1;
        dec_wbsel = 2'b01;
        dec_alu   = arith_op(funct3, funct7b5, 1'b0);
      end
      OP_LOAD: begin
        dec_bsel = 1'b1;
        is_load  = 1'b1;
      end
      OP_STORE: begin
        dec_imm  = 3'b001;
        dec_bsel = 1'b1;
        is_store = 1'b1;
      end
      OP_BRANCH: begin
        dec_imm   = 3'b010;
        dec_asel  = 1'b1;
        dec_bsel  = 1'b1;
        is_branch = 1'b1;
      end
      OP_LUI: begin
        dec_imm   = 3'b011;
        dec_bsel  = 1'b1;
        dec_wbsel = 2'b01;
        dec_alu   = ALU_PASSB;
      end
      OP_AUIPC: begin
        dec_imm   = 3'b011;
        dec_asel  = 1'b1;
        dec_bsel  = 1'b1;
        dec_wbsel = 2'b01;
      end
      OP_JAL: begin
        dec_imm   = 3'b100;
        dec_asel  = 1'b1;
        dec_bsel  = 1'b1;
        dec_wbsel = 2'b10;
        is_jump   = 1'b1;
      end
      OP_JALR: begin
        dec_bsel  = 1'b1;
        dec_wbsel = 2'b10;
        is_jump   = 1'b1;
      end
      default: legal = 1'b0;
    endcase
  end

  // Branch resolution; funct3 010/011 are not branches and never take
  always_comb begin
    case (funct3)
      3'b000:         br_taken = BrEq;
      3'b001:         br_taken = ~BrEq;
      3'b100, 3'b110: br_taken = BrLT;
      3'b101, 3'b111: br_taken = ~BrLT;
      default:        br_taken = 1'b0;
    endcase
  end

  // The wait counter reaches MEM_TIMEOUT only after that many ready-less
  // cycles; a ready arriving on that same cycle still completes the access
  always_comb begin
    waiting   = ((state == S_FETCH) || (state == S_MEM)) && !mem_ready;
    timed_out = (MEM_TIMEOUT != 0) && waiting &&
                (wait_cnt == WAIT_W'(MEM_TIMEOUT));
  end

  // Next-state and per-state controls; selects are shown only once the
  // instruction register holds the instruction being executed
  always_comb begin
    state_nxt  = state;
    mem_req    = 1'b0;
    mem_we     = 1'b0;
    AddrSel    = 1'b0;
    PCWrite    = 1'b0;
    RegWEn     = 1'b0;
    PCSel      = 1'b0;
    ImmSel     = 3'b000;
    ASel       = 1'b0;
    BSel       = 1'b0;
    BrUn       = 1'b0;
    WBSel      = 2'b00;
    ALUControl = ALU_ADD;
    ir_load    = 1'b0;
    retire     = 1'b0;
    cause_nxt  = 2'b00;
    show_sel   = 1'b0;
    case (state)
      S_RST: state_nxt = S_FETCH;
      S_FETCH: begin
        mem_req = 1'b1;
        if (mem_ready) begin
          ir_load   = 1'b1;
          state_nxt = S_DECODE;
        end else if (timed_out) begin
          cause_nxt = 2'b10;
          state_nxt = S_TRAP;
        end
      end
      S_DECODE: begin
        show_sel = 1'b1;
        if (legal) begin
          state_nxt = S_EXEC;
        end else begin
          cause_nxt = 2'b01;
          state_nxt = S_TRAP;
        end
      end
      S_EXEC: begin
        show_sel = 1'b1;
        if (is_branch) begin
          PCWrite   = 1'b1;
          PCSel     = br_taken;
          retire    = 1'b1;
          state_nxt = S_FETCH;
        end else if (is_load || is_store) begin
          state_nxt = S_MEM;
        end else begin
          state_nxt = S_WB;
        end
      end
      S_MEM: begin
        show_sel = 1'b1;
        mem_req  = 1'b1;
        AddrSel  = 1'b1;
        mem_we   = is_store;
        if (mem_ready) begin
          if (is_store) begin
            PCWrite   = 1'b1;
            retire    = 1'b1;
            state_nxt = S_FETCH;
          end else begin
            state_nxt = S_WB;
          end
        end else if (timed_out) begin
          cause_nxt = 2'b10;
          state_nxt = S_TRAP;
        end
      end
      S_WB: begin
        show_sel  = 1'b1;
        RegWEn    = 1'b1;
        PCWrite   = 1'b1;
        PCSel     = is_jump;
        retire    = 1'b1;
        state_nxt = S_FETCH;
      end
      S_TRAP: state_nxt = S_TRAP;
      default: state_nxt = S_RST;
    endcase
    if (show_sel) begin
      ImmSel     = dec_imm;
      ASel       = dec_asel;
      BSel       = dec_bsel;
      BrUn       = is_branch & funct3[1];
      WBSel      = dec_wbsel;
      ALUControl = dec_alu;
    end
  end

  // State, instruction register, retire counter, wait counter and sticky cause
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_RST;
      ir         <= '0;
      instret    <= '0;
      wait_cnt   <= '0;
      trap_cause <= 2'b00;
    end else begin
      state <= state_nxt;
      if (ir_load) ir <= mem_rdata;
      if (retire) instret <= instret + CNT_W'(1);
      wait_cnt <= waiting ? wait_cnt + WAIT_W'(1) : '0;
      if (cause_nxt != 2'b00) trap_cause <= cause_nxt;
    end
  end

endmodule

// File: tb/tb_multicycle_control_unit.sv
// tb_multicycle_control_unit
//   Self-checking bench for multicycle_control_unit. A transaction-level model
//   turns each instruction (plus its memory latencies and comparator flags)
//   into the expected cycle-by-cycle control trace, which is compared against
//   the DUT every cycle. A table of hand-decoded instructions, directed corner
//   sequences and a randomized run drive it.

`timescale 1ns/1ps
module tb_multicycle_control_unit;

  localparam int TO = 4;
  localparam int CW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [31:0]   mem_rdata;
  logic          mem_ready, BrEq, BrLT;
  logic          mem_req, mem_we, AddrSel, PCWrite, RegWEn, PCSel;
  logic [31:0]   ir;
  logic [2:0]    ImmSel;
  logic          ASel, BSel, BrUn;
  logic [1:0]    WBSel;
  logic [3:0]    ALUControl;
  logic          trap;
  logic [1:0]    trap_cause;
  logic [CW-1:0] instret;

  multicycle_control_unit #(.MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n), .mem_rdata(mem_rdata), .mem_ready(mem_ready),
    .BrEq(BrEq), .BrLT(BrLT), .mem_req(mem_req), .mem_we(mem_we),
    .AddrSel(AddrSel), .ir(ir), .PCWrite(PCWrite), .RegWEn(RegWEn),
    .PCSel(PCSel), .ImmSel(ImmSel), .ASel(ASel), .BSel(BSel), .BrUn(BrUn),
    .WBSel(WBSel), .ALUControl(ALUControl), .trap(trap),
    .trap_cause(trap_cause), .instret(instret)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic       mem_req, mem_we, addr_sel, pc_write, reg_wen, pc_sel;
    logic [2:0] imm_sel;
    logic       a_sel, b_sel, br_un;
    logic [1:0] wb_sel;
    logic [3:0] alu;
    logic       trap;
    logic [1:0] cause;
  } outs_t;

  typedef struct {
    logic [31:0] instr;
    int          fd, md;
    logic        eq, lt;
    logic [2:0]  imm;
    logic        a, b, brun;
    logic [1:0]  wb;
    logic [3:0]  alu;
  } vec_t;

  localparam logic [6:0] LEGAL_OPS [9] = '{7'h03, 7'h13, 7'h17, 7'h23, 7'h33,
                                           7'h37, 7'h63, 7'h67, 7'h6F};
  // ALU op by funct3 (index 0 in the low nibble): ADD SLL SLT SLTU XOR SRL OR AND
  localparam logic [31:0] ALU_BY_F3 = 32'h2364_9850;

  int    vecCount = 0;
  int    missCount = 0;
  int    refInstret;
  logic  [31:0] refIr;
  outs_t lastAct, seenSel;
  vec_t  vecs[$];

  function automatic bit isLegal(input logic [6:0] op);
    foreach (LEGAL_OPS[j]) if (LEGAL_OPS[j] == op) return 1'b1;
    return 1'b0;
  endfunction

  function automatic logic isTaken(input logic [2:0] f3, input logic eq, input logic lt);
    if (f3 == 3'd0) return eq;
    if (f3 == 3'd1) return !eq;
    if (f3 == 3'd4 || f3 == 3'd6) return lt;
    if (f3 == 3'd5 || f3 == 3'd7) return !lt;
    return 1'b0;
  endfunction

  // Datapath selects the instruction should present in its post-fetch states
  function automatic outs_t refSel(input logic [31:0] i);
    outs_t o = '0;
    int    f3 = int'(i[14:12]);
    logic [3:0] arith = ALU_BY_F3[f3*4 +: 4];
    case (i[6:0])
      7'h33: begin
        o.wb_sel = 2'd1; o.alu = arith;
        if (f3 == 0 && i[30]) o.alu = 4'h1;
        if (f3 == 5 && i[30]) o.alu = 4'h7;
      end
      7'h13: begin
        o.b_sel = 1; o.wb_sel = 2'd1; o.alu = arith;
        if (f3 == 5 && i[30]) o.alu = 4'h7;
      end
      7'h03: o.b_sel = 1;
      7'h23: begin o.imm_sel = 3'd1; o.b_sel = 1; end
      7'h63: begin o.imm_sel = 3'd2; o.a_sel = 1; o.b_sel = 1; o.br_un = i[13]; end
      7'h37: begin o.imm_sel = 3'd3; o.b_sel = 1; o.wb_sel = 2'd1; o.alu = 4'hA; end
      7'h17: begin o.imm_sel = 3'd3; o.a_sel = 1; o.b_sel = 1; o.wb_sel = 2'd1; end
      7'h6F: begin o.imm_sel = 3'd4; o.a_sel = 1; o.b_sel = 1; o.wb_sel = 2'd2; end
      7'h67: begin o.b_sel = 1; o.wb_sel = 2'd2; end
      default: ;
    endcase
    return o;
  endfunction

  function automatic outs_t dutOuts();
    outs_t o;
    o = {mem_req, mem_we, AddrSel, PCWrite, RegWEn, PCSel, ImmSel, ASel, BSel,
         BrUn, WBSel, ALUControl, trap, trap_cause};
    return o;
  endfunction

  task automatic applyStimulus(input logic rdy, input logic [31:0] rdata);
    mem_ready = rdy;
    mem_rdata = rdata;
    #2;
  endtask

  task automatic checkOutput(input string name, input outs_t exp);
    lastAct = dutOuts();
    vecCount++;
    if (lastAct !== exp) begin
      missCount++;
      $display("[TB] FAIL %s controls: got %h required %h", name, lastAct, exp);
    end
    vecCount++;
    if (ir !== refIr) begin
      missCount++;
      $display("[TB] FAIL %s ir: got %h required %h", name, ir, refIr);
    end
    vecCount++;
    if (instret !== CW'(refInstret)) begin
      missCount++;
      $display("[TB] FAIL %s instret: got %0d required %0d", name, instret, CW'(refInstret));
    end
  endtask

  // One clock: drive inputs just after the edge, check, advance past the next edge
  task automatic cycle(input string name, input logic rdy, input logic [31:0] rdata,
                       input outs_t exp);
    applyStimulus(rdy, rdata);
    checkOutput(name, exp);
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset, then the single RST cycle; leaves the DUT in FETCH
  task automatic doReset();
    #1 rst_n = 1'b0;
    mem_ready = 1'b0;
    #1;
    refIr = '0;
    refInstret = 0;
    checkOutput("reset_async", '0);
    @(posedge clk);
    #1 rst_n = 1'b1;
    cycle("rst_state", 1'b1, 32'h0000_0013, '0);
  endtask

  // Expected trace of one instruction from FETCH until it retires or traps.
  // fd/md: ready-less cycles before ready in fetch / memory access.
  task automatic runInstr(input logic [31:0] instr, input int fd, input int md,
                          input logic eq, input logic lt);
    outs_t      sel = refSel(instr);
    outs_t      e;
    logic [6:0] op = instr[6:0];
    logic [1:0] expCause = 2'b00;
    logic       rdy;
    bit         done = 0;
    BrEq = eq;
    BrLT = lt;
    for (int k = 0; k <= fd && !done; k++) begin
      e = '0;
      e.mem_req = 1;
      rdy = (k == fd);
      cycle("fetch", rdy, rdy ? instr : ~instr, e);
      if (rdy) refIr = instr;
      else if (k == TO) begin expCause = 2'b10; done = 1; end
    end
    if (!done) begin
      cycle("decode", 1'b0, ~instr, sel);
      if (!isLegal(op)) begin expCause = 2'b01; done = 1; end
    end
    if (!done) begin
      e = sel;
      if (op == 7'h63) begin e.pc_write = 1; e.pc_sel = isTaken(instr[14:12], eq, lt); end
      cycle("exec", 1'b0, ~instr, e);
      seenSel = lastAct;
      if (op == 7'h63) begin refInstret++; done = 1; end
    end
    if (!done && (op == 7'h03 || op == 7'h23)) begin
      for (int k = 0; k <= md && !done; k++) begin
        e = sel;
        e.mem_req = 1; e.addr_sel = 1; e.mem_we = (op == 7'h23);
        rdy = (k == md);
        if (rdy && op == 7'h23) e.pc_write = 1;
        cycle("mem", rdy, ~instr, e);
        if (rdy && op == 7'h23) begin refInstret++; done = 1; end
        else if (!rdy && k == TO) begin expCause = 2'b10; done = 1; end
      end
    end
    if (!done) begin
      e = sel;
      e.reg_wen = 1; e.pc_write = 1; e.pc_sel = (op == 7'h6F || op == 7'h67);
      cycle("wb", 1'b0, ~instr, e);
      refInstret++;
    end
    if (expCause != 2'b00) begin
      for (int k = 0; k < 2; k++) begin
        e = '0; e.trap = 1; e.cause = expCause;
        cycle("trap", 1'b1, instr, e);
      end
      doReset();
    end
  endtask

  task automatic addVec(input logic [31:0] instr, input int fd, input int md,
                        input logic eq, input logic lt, input logic [2:0] imm,
                        input logic a, input logic b, input logic brun,
                        input logic [1:0] wb, input logic [3:0] alu);
    vec_t v;
    v.instr = instr; v.fd = fd; v.md = md; v.eq = eq; v.lt = lt;
    v.imm = imm; v.a = a; v.b = b; v.brun = brun; v.wb = wb; v.alu = alu;
    vecs.push_back(v);
  endtask

  initial begin
    #1_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [31:0] r;
    logic [6:0]  op;
    int          fd, md;

    rst_n = 1'b0; mem_ready = 1'b0; mem_rdata = '0; BrEq = 1'b0; BrLT = 1'b0;
    refIr = '0; refInstret = 0;
    #3;
    checkOutput("power_on_reset", '0);
    @(posedge clk);
    #1;
    doReset();

    //     instr         fd md eq lt imm    a  b  brun wb     alu
    addVec(32'h002081B3, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd1, 4'h0);  // ADD
    addVec(32'h402081B3, 2, 0, 0, 0, 3'd0, 0, 0, 0, 2'd1, 4'h1);  // SUB
    addVec(32'h4020D1B3, 1, 0, 0, 0, 3'd0, 0, 0, 0, 2'd1, 4'h7);  // SRA
    addVec(32'h0020F1B3, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd1, 4'h2);  // AND
    addVec(32'h0020E1B3, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd1, 4'h3);  // OR
    addVec(32'h0020C1B3, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd1, 4'h4);  // XOR
    addVec(32'h002091B3, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd1, 4'h5);  // SLL
    addVec(32'h0020D1B3, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd1, 4'h6);  // SRL
    addVec(32'h0020A1B3, 0, 0, 0, 0, 3'd0, 0, 0, 0, 2'd1, 4'h8);  // SLT
    addVec(32'h40000093, 0, 0, 0, 0, 3'd0, 0, 1, 0, 2'd1, 4'h0);  // ADDI, imm bit 10 set
    addVec(32'h4030D093, 0, 0, 0, 0, 3'd0, 0, 1, 0, 2'd1, 4'h7);  // SRAI
    addVec(32'h0010B093, 0, 0, 0, 0, 3'd0, 0, 1, 0, 2'd1, 4'h9);  // SLTIU
    addVec(32'h0000A183, 0, 3, 0, 0, 3'd0, 0, 1, 0, 2'd0, 4'h0);  // LW, ready late
    addVec(32'h0020A223, 1, 1, 0, 0, 3'd1, 0, 1, 0, 2'd0, 4'h0);  // SW
    addVec(32'h00208463, 0, 0, 1, 0, 3'd2, 1, 1, 0, 2'd0, 4'h0);  // BEQ taken
    addVec(32'h00208463, 0, 0, 0, 0, 3'd2, 1, 1, 0, 2'd0, 4'h0);  // BEQ not taken
    addVec(32'h0020E463, 0, 0, 0, 1, 3'd2, 1, 1, 1, 2'd0, 4'h0);  // BLTU taken
    addVec(32'h0020D463, 0, 0, 0, 0, 3'd2, 1, 1, 0, 2'd0, 4'h0);  // BGE taken
    addVec(32'h123452B7, 0, 0, 0, 0, 3'd3, 0, 1, 0, 2'd1, 4'hA);  // LUI
    addVec(32'h00001297, 0, 0, 0, 0, 3'd3, 1, 1, 0, 2'd1, 4'h0);  // AUIPC
    addVec(32'h008000EF, 0, 0, 0, 0, 3'd4, 1, 1, 0, 2'd2, 4'h0);  // JAL
    addVec(32'h000080E7, 0, 0, 0, 0, 3'd0, 0, 1, 0, 2'd2, 4'h0);  // JALR

    for (int n = 0; n < vecs.size(); n++) begin
      runInstr(vecs[n].instr, vecs[n].fd, vecs[n].md, vecs[n].eq, vecs[n].lt);
      vecCount++;
      if ({seenSel.imm_sel, seenSel.a_sel, seenSel.b_sel, seenSel.br_un, seenSel.wb_sel, seenSel.alu}
          !== {vecs[n].imm, vecs[n].a, vecs[n].b, vecs[n].brun, vecs[n].wb, vecs[n].alu}) begin
        missCount++;
        $display("[TB] FAIL table[%0d] exec selects: got imm=%0d a=%0b b=%0b brun=%0b wb=%0d alu=%h required imm=%0d a=%0b b=%0b brun=%0b wb=%0d alu=%h",
                 n, seenSel.imm_sel, seenSel.a_sel, seenSel.b_sel, seenSel.br_un, seenSel.wb_sel, seenSel.alu,
                 vecs[n].imm, vecs[n].a, vecs[n].b, vecs[n].brun, vecs[n].wb, vecs[n].alu);
      end
    end

    // Ready arriving exactly at the timeout limit still completes the access
    runInstr(32'h0000A183, TO, TO, 0, 0);
    runInstr(32'h0020A223, TO, TO, 0, 0);
    // Illegal opcode, fetch timeout, load timeout, store timeout
    runInstr(32'h0000007F, 0, 0, 0, 0);
    runInstr(32'h002081B3, TO + 2, 0, 0, 0);
    runInstr(32'h0000A183, 0, TO + 1, 0, 0);
    runInstr(32'h0020A223, 1, TO + 3, 0, 0);

    // Reset while a fetch is waiting: request drops without a clock edge
    runInstr(32'h002081B3, 0, 0, 0, 0);
    cycle("fetch_wait", 1'b0, 32'hFFFF_FFFF, outs_t'(21'h10_0000));
    cycle("fetch_wait", 1'b0, 32'hFFFF_FFFF, outs_t'(21'h10_0000));
    doReset();
    runInstr(32'h002081B3, 0, 0, 0, 0);

    // Counter wrap: 1 + 259 retirements leaves 260 mod 256 = 4
    for (int n = 0; n < 259; n++) runInstr(32'h002081B3, 0, 0, 0, 0);
    vecCount++;
    if (instret !== 8'd4) begin
      missCount++;
      $display("[TB] FAIL instret_wrap: got %0d required 4", instret);
    end
    doReset();

    // Randomized instruction stream with random latencies and comparator flags
    for (int n = 0; n < 300; n++) begin
      r = $urandom();
      if ($urandom_range(0, 24) == 0) begin
        do op = 7'($urandom()); while (isLegal(op));
      end else begin
        op = LEGAL_OPS[$urandom_range(0, 8)];
      end
      fd = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, TO);
      md = ($urandom_range(0, 19) == 0) ? TO + 1 : $urandom_range(0, TO);
      runInstr({r[31:7], op}, fd, md, 1'($urandom()), 1'($urandom()));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule
